uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that serialises an arbitrary byte stream onto a single TX line. It pairs with the receive side of the board UART: upstream logic (command handlers, an echo path from the receiver) pushes bytes through a valid/ready handshake into an internal FIFO, and the block drains them back-to-back as standard frames. It replaces button-triggered fixed-string transmission as the general-purpose TX path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART encodings: one-hot TX FSM states and frame constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_START = 4'b0010,
      ST_DATA  = 4'b0100,
      ST_STOP  = 4'b1000
   } tx_state_t;

   localparam int c_data_bits            = 8;
   localparam int c_stop_bits            = 1;
   localparam int c_default_clks_per_bit = 235;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with wrap-bit pointers; drops pushes when full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [c_aw:0]      r_wr_ptr;
   logic [c_aw:0]      r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic               w_push;
   logic               w_pop;

   // Full blocks a push even when a pop lands on the same edge.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[c_aw-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Buffered 8N1 UART transmitter draining a byte FIFO back-to-back.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = c_default_clks_per_bit,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_busy,
   output logic                        o_tx
);

   localparam int              c_cw       = $clog2(CLKS_PER_BIT);
   localparam logic [c_cw-1:0] c_last_clk = c_cw'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      c_last_bit = 3'(c_data_bits - 1);

   tx_state_t        r_state, w_state_next;
   logic [c_cw-1:0]  r_clk_cnt, w_clk_cnt_next;
   logic [2:0]       r_bit_idx, w_bit_idx_next;
   logic [7:0]       r_shift, w_shift_next;
   logic             r_tx, w_tx_next;
   logic             w_pop;
   logic             w_bit_done;
   logic [7:0]       w_fifo_data;
   logic             w_full;
   logic             w_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_count)
   );

   assign w_bit_done = (r_clk_cnt == c_last_clk);

   always_comb begin
      w_state_next   = r_state;
      w_clk_cnt_next = r_clk_cnt;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_pop          = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_shift_next   = w_fifo_data;
               w_clk_cnt_next = '0;
               w_state_next   = ST_START;
            end
         end
         ST_START: begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
            if (w_bit_done) begin
               w_clk_cnt_next = '0;
               w_bit_idx_next = '0;
               w_state_next   = ST_DATA;
            end
         end
         ST_DATA: begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
            if (w_bit_done) begin
               w_clk_cnt_next = '0;
               w_shift_next   = {1'b0, r_shift[7:1]};
               w_bit_idx_next = r_bit_idx + 1'b1;
               if (r_bit_idx == c_last_bit) w_state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            w_clk_cnt_next = r_clk_cnt + 1'b1;
            if (w_bit_done) begin
               w_clk_cnt_next = '0;
               // Chain straight into the next start bit so frames abut.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_shift_next = w_fifo_data;
                  w_state_next = ST_START;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_clk_cnt_next = '0;
            w_state_next   = ST_IDLE;
         end
      endcase

      // Line level is registered from the upcoming state to keep o_tx glitch-free.
      unique case (w_state_next)
         ST_START: w_tx_next = 1'b0;
         ST_DATA:  w_tx_next = w_shift_next[0];
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_clk_cnt <= w_clk_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_tx      <= w_tx_next;
      end
   end

   assign o_tx    = r_tx;
   assign o_busy  = (r_state != ST_IDLE);
   assign o_ready = !w_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Scoreboard bench for uart_tx_fifo; a line monitor decodes frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;

   localparam int C_CPB   = 4;
   localparam int C_DEPTH = 8;
   localparam int C_FRAME = 10 * C_CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] i_data = 8'h00;
   logic       i_valid = 1'b0;
   logic       o_ready;
   logic [3:0] o_count;
   logic       o_busy;
   logic       o_tx;

   int         checks = 0;
   int         failures = 0;
   int         frames = 0;
   int         busy_cyc = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(
      .CLKS_PER_BIT (C_CPB),
      .FIFO_DEPTH   (C_DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_count (o_count),
      .o_busy  (o_busy),
      .o_tx    (o_tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) if (!rst && o_busy) busy_cyc++;

   // Line monitor: samples every cycle of a frame and compares to the queued byte.
   initial begin : mon
      logic [C_FRAME-1:0] line, exp_line;
      logic [7:0]         exp_b, got;
      bit                 busy_ok, aborted;
      int                 bitno;
      forever begin
         @(negedge clk);
         if (!rst && o_tx == 1'b0) begin
            check("frame_expected", exp_q.size() != 0, 1);
            exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            line = '0;
            line[0] = o_tx;
            busy_ok = o_busy;
            aborted = 0;
            for (int k = 1; k < C_FRAME; k++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1;
                  break;
               end
               line[k] = o_tx;
               if (!o_busy) busy_ok = 0;
            end
            if (!aborted) begin
               for (int k = 0; k < C_FRAME; k++) begin
                  bitno = k / C_CPB;
                  if (bitno == 0)      exp_line[k] = 1'b0;
                  else if (bitno == 9) exp_line[k] = 1'b1;
                  else                 exp_line[k] = exp_b[bitno-1];
               end
               for (int i = 0; i < 8; i++) got[i] = line[(i+1)*C_CPB + C_CPB/2];
               check("frame_line", line, exp_line);
               check("frame_byte", got, exp_b);
               check("frame_busy", busy_ok, 1);
               frames++;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b, output bit acc);
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = b;
      acc     = o_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(b);
   endtask

   task automatic idle_valid();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      bit acc;
      int n = 0;
      do begin
         push(b, acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) check("send_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((o_busy || o_count != 0) && n < max) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", n < max, 1);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   acc, low_seen;
      int   b0, f0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", o_tx, 1);
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 1);
      check("rst_count", o_count, 0);
      @(negedge clk) rst = 1'b0;

      // Single byte: start bit two edges after valid rises, 40 busy cycles.
      b0 = busy_cyc; f0 = frames;
      push(8'h55, acc);
      #1;
      check("t1_count_after_push", o_count, 1);
      check("t1_tx_still_idle", o_tx, 1);
      check("t1_busy_before_pop", o_busy, 0);
      idle_valid();
      @(posedge clk);
      #1;
      check("t1_tx_start", o_tx, 0);
      check("t1_busy_start", o_busy, 1);
      check("t1_count_after_pop", o_count, 0);
      wait_idle(200);
      check("t1_busy_cycles", busy_cyc - b0, 40);
      check("t1_frames", frames - f0, 1);

      // Back-to-back frames with no idle gap.
      b0 = busy_cyc; f0 = frames;
      push(8'hA3, acc);
      push(8'h0F, acc);
      push(8'hFF, acc);
      idle_valid();
      wait_idle(400);
      check("t2_busy_cycles", busy_cyc - b0, 120);
      check("t2_frames", frames - f0, 3);
      check("t2_queue_drained", exp_q.size(), 0);

      // Overfill while the first frame is on the line.
      f0 = frames;
      for (int i = 0; i < 10; i++) begin
         push(8'h30 + 8'(i), acc);
         check("t3_accept", acc, (i < 9) ? 1 : 0);
         if (i == 8) begin
            #1;
            check("t3_count_full", o_count, 8);
            check("t3_ready_low", o_ready, 0);
         end
      end
      idle_valid();
      wait_idle(1000);
      check("t3_frames", frames - f0, 9);
      check("t3_queue_drained", exp_q.size(), 0);

      // Push on the last STOP cycle while one byte is queued.
      f0 = frames;
      push(8'h81, acc);
      push(8'h42, acc);
      #1;
      check("t4_count_queued", o_count, 1);
      idle_valid();
      repeat (38) @(negedge clk);
      push(8'hE7, acc);
      #1;
      check("t4_count_simul", o_count, 1);
      check("t4_tx_restart", o_tx, 0);
      idle_valid();
      wait_idle(400);
      check("t4_frames", frames - f0, 3);
      check("t4_queue_drained", exp_q.size(), 0);

      // Reset during DATA bit 3 with four bytes queued.
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), acc);
      idle_valid();
      repeat (14) @(posedge clk);
      #2;
      exp_q.delete();
      rst = 1'b1;
      #1;
      check("t5_tx_high", o_tx, 1);
      check("t5_busy_low", o_busy, 0);
      check("t5_count_zero", o_count, 0);
      check("t5_ready_high", o_ready, 1);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      f0 = frames;
      low_seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (o_tx == 1'b0 || o_busy) low_seen = 1;
      end
      check("t5_line_quiet", low_seen, 0);
      check("t5_no_frames", frames - f0, 0);

      // Every byte value plus random bytes with random valid gaps.
      f0 = frames;
      for (int v = 0; v < 276; v++) begin
         send((v < 256) ? 8'(v) : 8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            idle_valid();
            repeat ($urandom_range(0, 5)) @(negedge clk);
         end
      end
      idle_valid();
      wait_idle(1000);
      check("t6_frames", frames - f0, 276);
      check("t6_queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
